// File: rtl/sd_to_apc_buf.sv
// Valid/ready to two-phase (toggle) bridge: FIFO-buffered items launched one at a time on p_ph_send, acked by p_ph_ack.
// Latency: push into idle empty block launches next edge; c_drdy drops only when FIFO holds depth items.
module sd_to_apc_buf #(
    parameter int width       = 32,
    parameter int depth       = 4,
    parameter int sync_stages = 2,
    parameter int timeout     = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         c_srdy,
    output logic                         c_drdy,
    input  logic [width-1:0]             c_data,
    output logic                         p_ph_send,
    output logic [width-1:0]             p_data,
    input  logic                         p_ph_ack,
    output logic [$clog2(depth+1)-1:0]   usage,
    input  logic                         err_clr,
    output logic                         timeout_err,
    output logic                         spurious_err
);
    localparam int aw = $clog2(depth);
    localparam int uw = $clog2(depth + 1);
    localparam logic [15:0] tmo_lim = 16'(timeout);

    typedef enum logic {IDLE, TX} state_t;

    state_t                 state;
    logic [width-1:0]       mem [depth];
    logic [aw-1:0]          wr_ptr;
    logic [aw-1:0]          rd_ptr;
    logic [sync_stages-1:0] sync_chain;
    logic                   sync_ack;
    logic                   dly_ack;
    logic                   ack_edge;
    logic [15:0]            tmo_cnt;
    logic                   push;
    logic                   launch;
    logic                   fifo_empty;
    logic                   tmo_inc;
    logic                   tmo_set;
    logic                   spur_set;

    assign c_drdy     = (usage != uw'(depth));
    assign fifo_empty = (usage == '0);
    assign push       = c_srdy & c_drdy;
    assign sync_ack   = sync_chain[sync_stages-1];
    assign ack_edge   = sync_ack ^ dly_ack;
    // In TX the next item may only go once the current one is acked.
    assign launch     = !fifo_empty && ((state == IDLE) || ack_edge);
    assign tmo_inc    = (state == TX) && !ack_edge && (tmo_cnt != 16'hFFFF);
    assign tmo_set    = (tmo_lim != 16'd0) && tmo_inc && ((tmo_cnt + 16'd1) == tmo_lim);
    assign spur_set   = (state == IDLE) && ack_edge;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= c_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            p_ph_send    <= 1'b0;
            p_data       <= '0;
            usage        <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            sync_chain   <= '0;
            dly_ack      <= 1'b0;
            tmo_cnt      <= '0;
            timeout_err  <= 1'b0;
            spurious_err <= 1'b0;
        end else begin
            sync_chain <= {sync_chain[sync_stages-2:0], p_ph_ack};
            dly_ack    <= sync_ack;

            if (push) begin
                wr_ptr <= wr_ptr + aw'(1);
            end
            if (launch) begin
                rd_ptr <= rd_ptr + aw'(1);
            end
            case ({push, launch})
                2'b10:   usage <= usage + uw'(1);
                2'b01:   usage <= usage - uw'(1);
                default: usage <= usage;
            endcase

            if (launch) begin
                p_data    <= mem[rd_ptr];
                p_ph_send <= ~p_ph_send;
                state     <= TX;
                tmo_cnt   <= '0;
            end else if ((state == TX) && ack_edge) begin
                state <= IDLE;
            end else if (tmo_inc) begin
                tmo_cnt <= tmo_cnt + 16'd1;
            end

            // A set event in the same cycle as err_clr keeps the flag.
            timeout_err  <= tmo_set  | (timeout_err  & ~err_clr);
            spurious_err <= spur_set | (spurious_err & ~err_clr);
        end
    end
endmodule

// File: tb/tb_sd_to_apc_buf.sv
// Randomized bench for sd_to_apc_buf with a queue-based reference model and in-order send scoreboard.
module tb_sd_to_apc_buf;
    localparam int W     = 32;
    localparam int DEPTH = 4;
    localparam int SYNC  = 2;
    localparam int TMO   = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          c_srdy;
    logic          c_drdy;
    logic [W-1:0]  c_data;
    logic          p_ph_send;
    logic [W-1:0]  p_data;
    logic          p_ph_ack;
    logic [2:0]    usage;
    logic          err_clr;
    logic          timeout_err;
    logic          spurious_err;

    sd_to_apc_buf #(.width(W), .depth(DEPTH), .sync_stages(SYNC), .timeout(TMO)) dut (
        .clk(clk), .reset(reset), .c_srdy(c_srdy), .c_drdy(c_drdy), .c_data(c_data),
        .p_ph_send(p_ph_send), .p_data(p_data), .p_ph_ack(p_ph_ack), .usage(usage),
        .err_clr(err_clr), .timeout_err(timeout_err), .spurious_err(spurious_err)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [W-1:0] m_q[$];
    logic [W-1:0] acc_q[$];
    bit           m_busy = 1'b0;
    bit           m_send = 1'b0;
    logic [W-1:0] m_data = '0;
    int           m_cnt  = 0;
    bit           m_terr = 1'b0;
    bit           m_serr = 1'b0;
    bit [7:0]     ahist  = '0;

    int   errors  = 0;
    int   checks  = 0;
    int   toggles = 0;
    bit   chk_en  = 1'b0;
    logic last_send = 1'b0;
    bit   echo_en = 1'b0;
    logic [2:0] send_d = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model
        bit ae;
        bit launch;
        bit push;
        bit set_t;
        bit set_s;
        int sz;
        if (reset) begin
            m_q.delete();
            acc_q.delete();
            m_busy = 1'b0;
            m_send = 1'b0;
            m_data = '0;
            m_cnt  = 0;
            m_terr = 1'b0;
            m_serr = 1'b0;
            ahist  = '0;
        end else begin
            ae     = ahist[SYNC-1] ^ ahist[SYNC];
            sz     = m_q.size();
            push   = c_srdy && (sz != DEPTH);
            launch = (sz != 0) && (!m_busy || ae);
            set_s  = !m_busy && ae;
            set_t  = 1'b0;
            if (launch) begin
                m_data = m_q.pop_front();
                m_send = !m_send;
                m_busy = 1'b1;
                m_cnt  = 0;
            end else if (m_busy && ae) begin
                m_busy = 1'b0;
            end else if (m_busy && m_cnt < 65535) begin
                m_cnt++;
                if (TMO != 0 && m_cnt == TMO) set_t = 1'b1;
            end
            m_terr = set_t || (m_terr && !err_clr);
            m_serr = set_s || (m_serr && !err_clr);
            if (push) begin
                m_q.push_back(c_data);
                acc_q.push_back(c_data);
            end
            ahist = {ahist[6:0], p_ph_ack};
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("c_drdy", 32'(c_drdy), 32'(m_q.size() != DEPTH));
            chk("usage", 32'(usage), 32'(m_q.size()));
            chk("p_ph_send", 32'(p_ph_send), 32'(m_send));
            chk("p_data", p_data, m_data);
            chk("timeout_err", 32'(timeout_err), 32'(m_terr));
            chk("spurious_err", 32'(spurious_err), 32'(m_serr));
            if (reset) begin
                last_send = 1'b0;
            end else if (p_ph_send !== last_send) begin
                last_send = p_ph_send;
                toggles++;
                if (acc_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL send_order: toggle with data %h, required no toggle", p_data);
                end else begin
                    chk("send_order", p_data, acc_q.pop_front());
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
        if (echo_en) begin
            p_ph_ack = send_d[2];
            send_d   = {send_d[1:0], p_ph_send};
        end
    endtask

    task automatic push_one(input logic [W-1:0] d);
        c_srdy = 1'b1;
        c_data = d;
        cycle();
        c_srdy = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc, input string tag);
        int n;
        n = 0;
        while ((m_q.size() != 0 || m_busy) && n < max_cyc) begin
            cycle();
            n++;
        end
        checks++;
        if (n >= max_cyc) begin
            errors++;
            $display("FAIL %s: still busy after %0d cycles, required idle", tag, n);
        end
        repeat (4) cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int sent;
        int guard;
        bit acc;
        reset = 1'b1; c_srdy = 1'b0; c_data = '0; p_ph_ack = 1'b0; err_clr = 1'b0;
        cycle();
        chk_en = 1'b1;
        cycle();
        reset = 1'b0;
        chk("rst_usage", 32'(usage), 32'd0);
        chk("rst_c_drdy", 32'(c_drdy), 32'd1);
        chk("rst_send", 32'(p_ph_send), 32'd0);
        chk("rst_p_data", p_data, 32'd0);
        chk("rst_terr", 32'(timeout_err), 32'd0);
        chk("rst_serr", 32'(spurious_err), 32'd0);

        // Single item
        push_one(32'hA5A5_0001);
        chk("single_pre_send", 32'(p_ph_send), 32'd0);
        cycle();
        chk("single_send", 32'(p_ph_send), 32'd1);
        chk("single_data", p_data, 32'hA5A5_0001);
        chk("single_usage", 32'(usage), 32'd0);
        p_ph_ack = 1'b1;
        repeat (SYNC + 1) cycle();
        push_one(32'h0000_B00B);
        cycle();
        chk("idle_relaunch_send", 32'(p_ph_send), 32'd0);
        chk("idle_relaunch_data", p_data, 32'h0000_B00B);
        p_ph_ack = 1'b0;
        repeat (4) cycle();

        // Fill with ack held
        t0 = toggles;
        c_srdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            c_data = 32'h100 + 32'(i);
            cycle();
        end
        c_srdy = 1'b0;
        chk("fill_usage", 32'(usage), 32'd4);
        chk("fill_c_drdy", 32'(c_drdy), 32'd0);
        chk("fill_data", p_data, 32'h100);
        chk("fill_toggles", 32'(toggles - t0), 32'd1);
        repeat (12) cycle();
        chk("fill_no_more_toggles", 32'(toggles - t0), 32'd1);
        chk("fill_terr", 32'(timeout_err), 32'd1);
        send_d  = {3{p_ph_send}};
        echo_en = 1'b1;
        wait_idle(200, "fill_drain");
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        chk("fill_terr_clr", 32'(timeout_err), 32'd0);

        // Back-to-back with echo responder
        t0 = toggles; sent = 0; guard = 0;
        while (sent < 16 && guard < 400) begin
            acc    = (m_q.size() != DEPTH);
            c_srdy = 1'b1;
            c_data = $urandom();
            cycle();
            if (acc) sent++;
            guard++;
        end
        c_srdy = 1'b0;
        chk("b2b_push_bound", 32'(guard < 400), 32'd1);
        wait_idle(200, "b2b_drain");
        chk("b2b_toggles", 32'(toggles - t0), 32'd16);
        chk("b2b_terr", 32'(timeout_err), 32'd0);
        chk("b2b_serr", 32'(spurious_err), 32'd0);

        // Random traffic
        repeat (300) begin
            c_srdy  = 1'($urandom_range(0, 1));
            c_data  = $urandom();
            err_clr = ($urandom_range(0, 15) == 0);
            cycle();
        end
        c_srdy  = 1'b0;
        err_clr = 1'b0;
        wait_idle(200, "rand_drain");
        echo_en = 1'b0;

        // Timeout
        push_one(32'hDEAD_0010);
        cycle();
        chk("tmo_data", p_data, 32'hDEAD_0010);
        repeat (9) cycle();
        chk("tmo_before", 32'(timeout_err), 32'd0);
        cycle();
        chk("tmo_hit", 32'(timeout_err), 32'd1);
        p_ph_ack = ~p_ph_ack;
        repeat (SYNC + 2) cycle();
        chk("tmo_late_ack_idle", 32'(m_busy), 32'd0);
        chk("tmo_sticky", 32'(timeout_err), 32'd1);
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        chk("tmo_clr", 32'(timeout_err), 32'd0);

        // Spurious ack in IDLE
        p_ph_ack = ~p_ph_ack;
        repeat (SYNC + 1) cycle();
        chk("spur_set", 32'(spurious_err), 32'd1);
        chk("spur_send_held", 32'(p_ph_send), 32'(m_send));
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        chk("spur_clr", 32'(spurious_err), 32'd0);
        p_ph_ack = ~p_ph_ack;
        repeat (SYNC) cycle();
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        chk("spur_set_wins", 32'(spurious_err), 32'd1);
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;

        // Reset mid-transfer
        c_srdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            c_data = 32'h300 + 32'(i);
            cycle();
        end
        c_srdy = 1'b0;
        chk("mid_usage", 32'(usage), 32'd3);
        chk("mid_data", p_data, 32'h300);
        reset    = 1'b1;
        p_ph_ack = 1'b0;
        cycle();
        reset = 1'b0;
        chk("mid_rst_usage", 32'(usage), 32'd0);
        chk("mid_rst_send", 32'(p_ph_send), 32'd0);
        chk("mid_rst_c_drdy", 32'(c_drdy), 32'd1);
        cycle();
        t0 = toggles;
        repeat (5) cycle();
        chk("mid_no_toggle", 32'(toggles - t0), 32'd0);
        push_one(32'h0000_0400);
        cycle();
        chk("mid_new_send", 32'(p_ph_send), 32'd1);
        chk("mid_new_data", p_data, 32'h0000_0400);
        repeat (2) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
